// File: rtl/multicycle_arith_machine.sv
// multicycle_arith_machine: FETCH/EXEC/WB MIPS ALU subset; ports: clock/reset, inst_req/inst_addr/inst_valid/inst_data fetch port, except, retired, dbg_addr/dbg_data register read
module multicycle_arith_machine #(
  parameter int DATA_W   = 32,
  parameter int RETIRE_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  output logic                inst_req,
  output logic [DATA_W-1:0]   inst_addr,
  input  logic                inst_valid,
  input  logic [31:0]         inst_data,
  output logic                except,
  output logic [RETIRE_W-1:0] retired,
  input  logic [4:0]          dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);
  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] pc, res, alu, a, b, sext, zext;
  logic [DATA_W-1:0] regs [32];
  logic [31:0] ir;
  logic [4:0] dst, dst_nx;
  logic legal;
  wire [5:0]  op    = ir[31:26];
  wire [4:0]  rs    = ir[25:21];
  wire [4:0]  rt    = ir[20:16];
  wire [4:0]  rd    = ir[15:11];
  wire [5:0]  funct = ir[5:0];
  wire [15:0] imm   = ir[15:0];
  assign a         = rs == 5'd0 ? '0 : regs[rs];
  assign b         = rt == 5'd0 ? '0 : regs[rt];
  assign sext      = {{(DATA_W-16){imm[15]}}, imm};
  assign zext      = {{(DATA_W-16){1'b0}}, imm};
  assign inst_req  = state == FETCH;
  assign inst_addr = pc;
  assign except    = state == HALT;
  assign dbg_data  = dbg_addr == 5'd0 ? '0 : regs[dbg_addr];
  always_comb begin
    legal  = 1'b1;
    alu    = '0;
    dst_nx = rt;
    if (op == 6'h00) begin
      dst_nx = rd;
      case (funct)
        6'h20:   alu = a + b;
        6'h22:   alu = a - b;
        6'h24:   alu = a & b;
        6'h25:   alu = a | b;
        6'h26:   alu = a ^ b;
        6'h27:   alu = ~(a | b);
        default: legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08:   alu = a + sext;
        6'h0C:   alu = a & zext;
        6'h0D:   alu = a | zext;
        6'h0E:   alu = a ^ zext;
        default: legal = 1'b0;
      endcase
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = inst_valid ? EXEC : FETCH;
      EXEC:    state_nx = legal ? WB : HALT;
      WB:      state_nx = FETCH;
      default: state_nx = HALT;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= '0;
      ir      <= '0;
      res     <= '0;
      dst     <= '0;
      retired <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      if (state == FETCH && inst_valid) ir <= inst_data;
      if (state == EXEC) begin
        res <= alu;
        dst <= dst_nx;
      end
      if (state == WB) begin
        if (dst != 5'd0) regs[dst] <= res;
        pc      <= pc + DATA_W'(4);
        retired <= retired + RETIRE_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_multicycle_arith_machine.sv
// tb_multicycle_arith_machine: directed-vector bench for the 32-bit and a 16-bit/2-bit-retire build
module tb_multicycle_arith_machine;
  logic clock = 1'b0;
  logic reset = 1'b1, reset2 = 1'b1;
  logic inst_valid = 1'b1;
  logic [4:0] dbg_addr = '0, dbg_addr2 = '0;
  logic inst_req, except, inst_req2, except2;
  logic [31:0] inst_addr, dbg_data;
  logic [15:0] retired;
  logic [15:0] inst_addr2, dbg_data2;
  logic [1:0] retired2;
  logic [31:0] mem [16];
  logic [31:0] mem2 [16];
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;
  multicycle_arith_machine dut (
    .clock(clock), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_valid(inst_valid), .inst_data(mem[inst_addr[5:2]]), .except(except),
    .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  multicycle_arith_machine #(.DATA_W(16), .RETIRE_W(2)) dut16 (
    .clock(clock), .reset(reset2), .inst_req(inst_req2), .inst_addr(inst_addr2),
    .inst_valid(1'b1), .inst_data(mem2[inst_addr2[5:2]]), .except(except2),
    .retired(retired2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reg_chk(input string tag, input logic [4:0] idx, input logic [63:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
  endtask
  task automatic clear_mem;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0020;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) mem2[i] = 32'h0000_0020;
    mem2[0] = 32'h2001_7FFF;
    mem2[1] = 32'h2021_0001;
    clear_mem();
    mem[0] = 32'h2001_FFFF;
    mem[1] = 32'h2002_0005;
    mem[2] = 32'h0022_1820;
    do_reset();
    chk("rst_req", inst_req, 1);
    chk("rst_addr", inst_addr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_except", except, 0);
    step(9);
    reg_chk("p1_r1", 1, 64'hFFFF_FFFF);
    reg_chk("p1_r2", 2, 5);
    reg_chk("p1_r3", 3, 4);
    chk("p1_retired", retired, 3);
    chk("p1_addr", inst_addr, 12);
    do_reset();
    reg_chk("rst_clears_r1", 1, 0);
    step(4);
    chk("mid_retired", retired, 1);
    reset = 1'b1;
    #1;
    chk("async_retired", retired, 0);
    chk("async_addr", inst_addr, 0);
    reg_chk("async_r1", 1, 0);
    mem[0] = 32'h3404_8000;
    mem[1] = 32'h3085_FFFF;
    mem[2] = 32'h0000_3027;
    do_reset();
    step(9);
    reg_chk("p2_r4", 4, 32'h0000_8000);
    reg_chk("p2_r5", 5, 32'h0000_8000);
    reg_chk("p2_r6", 6, 32'hFFFF_FFFF);
    mem[0] = 32'h2001_FFFF;
    mem[1] = 32'h2002_0005;
    mem[2] = 32'h0022_1820;
    inst_valid = 1'b0;
    do_reset();
    step(5);
    chk("wait_req", inst_req, 1);
    chk("wait_addr", inst_addr, 0);
    chk("wait_retired", retired, 0);
    inst_valid = 1'b1;
    step(2);
    chk("wait_retired_2", retired, 0);
    step(1);
    chk("wait_retired_3", retired, 1);
    chk("wait_addr_3", inst_addr, 4);
    reg_chk("wait_r1", 1, 64'hFFFF_FFFF);
    clear_mem();
    mem[0] = 32'h2000_0007;
    mem[1] = 32'h0000_3820;
    do_reset();
    step(6);
    reg_chk("r0_zero", 0, 0);
    reg_chk("r7_zero", 7, 0);
    chk("r0_retired", retired, 2);
    clear_mem();
    mem[2] = 32'hFC00_0000;
    do_reset();
    step(7);
    chk("exc_before", except, 0);
    chk("exc_fetch_addr", inst_addr, 8);
    step(1);
    chk("exc_set", except, 1);
    chk("exc_req", inst_req, 0);
    chk("exc_addr", inst_addr, 8);
    chk("exc_retired", retired, 2);
    step(20);
    chk("halt_except", except, 1);
    chk("halt_req", inst_req, 0);
    chk("halt_addr", inst_addr, 8);
    chk("halt_retired", retired, 2);
    reset = 1'b1;
    #1;
    chk("exc_cleared", except, 0);
    reset = 1'b0;
    #1;
    chk("exc_req_back", inst_req, 1);
    reset2 = 1'b1;
    @(negedge clock);
    reset2 = 1'b0;
    #1;
    chk("w16_rst_retired", retired2, 0);
    step(6);
    dbg_addr2 = 5'd1;
    #1;
    chk("w16_r1", dbg_data2, 16'h8000);
    chk("w16_except", except2, 0);
    step(3);
    chk("w16_retired_3", retired2, 3);
    step(3);
    chk("w16_retired_wrap", retired2, 0);
    chk("w16_addr", inst_addr2, 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
